fetch_buffer_ctrl: RTL and testbench

// - Parametrised successor to the fixed 4-wide fetch stage; owns the fetch PC, issues FETCH_W-wide imem reads.
// - Applies branch-predictor redirects and ROB recovery; drops wrong-path responses using an epoch bit.
// - Queues fetch groups in a DEPTH-entry buffer. Decode consumes them through a valid/ready handshake.
// - Sits between instruction memory/predictor and DECODE; replaces the stall_fetch back-pressure wire.

---
 rtl/fetch_buffer_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_fetch_buffer_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer_ctrl.sv
// Fetch PC owner and DEPTH-entry fetch-group buffer between imem/predictor and decode.
// Optional feature: define FETCH_PERF_CNT_EN to add 32-bit saturating perf counters.

module fetch_buffer_ctrl_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             enq,
    input logic [CNT_W-1:0] count
);

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
        !(enq && (count == CNT_W'(DEPTH))));

    a_count_bounded: assert property (@(posedge clk) disable iff (rst)
        (count <= CNT_W'(DEPTH)));

endmodule

module fetch_buffer_ctrl #(
    parameter int              FETCH_W  = 4,
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic                      imem_rvld,
    input  logic [FETCH_W*INST_W-1:0] imem_rdata,
    input  logic [FETCH_W-1:0]        bp_taken,
    input  logic [PC_W-1:0]           bp_target,
    input  logic                      has_mispredict,
    input  logic [PC_W-1:0]           pc_recovery,
    input  logic                      dec_rdy,
    output logic                      dec_vld,
    output logic [PC_W-1:0]           dec_pc,
    output logic [FETCH_W*INST_W-1:0] dec_inst,
    output logic [FETCH_W-1:0]        dec_lane_vld,
    output logic [FETCH_W-1:0]        dec_pred
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_groups,
    output logic [31:0]               perf_flush,
    output logic [31:0]               perf_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int GRP_W = FETCH_W * INST_W;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             epoch_q, epoch_d;
    logic             inflight_q;
    logic             inflight_epoch_q;
    logic [PC_W-1:0]  inflight_pc_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [PC_W-1:0]    buf_pc_q   [DEPTH];
    logic [GRP_W-1:0]   buf_inst_q [DEPTH];
    logic [FETCH_W-1:0] buf_lv_q   [DEPTH];
    logic [FETCH_W-1:0] buf_pred_q [DEPTH];

    logic [CNT_W-1:0]   occ_s;
    logic               req_s;
    logic               rsp_ok_s;
    logic               taken_s;
    logic               enq_s;
    logic               deq_s;
    logic               dec_vld_s;
    logic [FETCH_W-1:0] pred_s;
    logic [FETCH_W-1:0] lane_vld_s;

    // Credit check counts the response still in flight so the buffer can never overflow.
    assign occ_s     = count_q + {{(CNT_W-1){1'b0}}, inflight_q};
    assign req_s     = !rst && !has_mispredict && (occ_s < CNT_W'(DEPTH));
    assign rsp_ok_s  = imem_rvld && inflight_q && (inflight_epoch_q == epoch_q) && !has_mispredict;
    assign taken_s   = rsp_ok_s && (bp_taken != {FETCH_W{1'b0}});
    assign enq_s     = rsp_ok_s;
    assign dec_vld_s = (count_q != {CNT_W{1'b0}});
    assign deq_s     = dec_vld_s && dec_rdy;

    // Isolate lowest taken lane; lanes up to it are valid (all lanes when none is taken).
    assign pred_s     = bp_taken & (~bp_taken + FETCH_W'(1));
    assign lane_vld_s = pred_s | (pred_s - FETCH_W'(1));

    assign imem_req  = req_s;
    assign imem_addr = req_s ? pc_q : {PC_W{1'b0}};

    assign dec_vld      = dec_vld_s;
    assign dec_pc       = dec_vld_s ? buf_pc_q[head_q]   : {PC_W{1'b0}};
    assign dec_inst     = dec_vld_s ? buf_inst_q[head_q] : {GRP_W{1'b0}};
    assign dec_lane_vld = dec_vld_s ? buf_lv_q[head_q]   : {FETCH_W{1'b0}};
    assign dec_pred     = dec_vld_s ? buf_pred_q[head_q] : {FETCH_W{1'b0}};

    // Next-state for PC, epoch and buffer pointers; recovery outranks prediction.
    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (has_mispredict) begin
            pc_d    = pc_recovery;
            epoch_d = ~epoch_q;
            count_d = {CNT_W{1'b0}};
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
        end else begin
            if (taken_s) begin
                pc_d    = bp_target;
                epoch_d = ~epoch_q;
            end else if (req_s) begin
                pc_d = pc_q + PC_W'(FETCH_W);
            end else begin
                pc_d = pc_q;
            end
            if (enq_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
        end
    end

    // Control state registers; the in-flight tag remembers the epoch and PC of the issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= {PC_W{1'b0}};
            count_q          <= {CNT_W{1'b0}};
            head_q           <= {PTR_W{1'b0}};
            tail_q           <= {PTR_W{1'b0}};
        end else begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= req_s;
            if (req_s) begin
                inflight_epoch_q <= epoch_q;
                inflight_pc_q    <= pc_q;
            end else begin
                inflight_epoch_q <= inflight_epoch_q;
                inflight_pc_q    <= inflight_pc_q;
            end
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Group storage written at the tail on an accepted response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= {PC_W{1'b0}};
                buf_inst_q[i] <= {GRP_W{1'b0}};
                buf_lv_q[i]   <= {FETCH_W{1'b0}};
                buf_pred_q[i] <= {FETCH_W{1'b0}};
            end
        end else if (enq_s) begin
            buf_pc_q[tail_q]   <= inflight_pc_q;
            buf_inst_q[tail_q] <= imem_rdata;
            buf_lv_q[tail_q]   <= lane_vld_s;
            buf_pred_q[tail_q] <= pred_s;
        end else begin
            buf_pc_q[tail_q] <= buf_pc_q[tail_q];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_groups_q;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_groups_q <= 32'd0;
            perf_flush_q  <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            if (deq_s && (perf_groups_q != 32'hFFFF_FFFF)) begin
                perf_groups_q <= perf_groups_q + 32'd1;
            end else begin
                perf_groups_q <= perf_groups_q;
            end
            if (has_mispredict && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end else begin
                perf_flush_q <= perf_flush_q;
            end
            if (dec_vld_s && !dec_rdy && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_groups = perf_groups_q;
    assign perf_flush  = perf_flush_q;
    assign perf_stall  = perf_stall_q;
`endif

    fetch_buffer_ctrl_chk #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq_s),
        .count (count_q)
    );

endmodule

// File: tb/tb_fetch_buffer_ctrl.sv
// Directed bench for fetch_buffer_ctrl with an imem/predictor responder and an expected-group queue.
module tb_fetch_buffer_ctrl;

    localparam int FETCH_W = 4;
    localparam int PC_W    = 16;
    localparam int INST_W  = 16;
    localparam int DEPTH   = 4;
    localparam int GRP_W   = FETCH_W * INST_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvld = 1'b0;
    logic [GRP_W-1:0]   imem_rdata = '0;
    logic [FETCH_W-1:0] bp_taken = '0;
    logic [PC_W-1:0]    bp_target = '0;
    logic               has_mispredict = 1'b0;
    logic [PC_W-1:0]    pc_recovery = '0;
    logic               dec_rdy = 1'b0;
    logic               dec_vld;
    logic [PC_W-1:0]    dec_pc;
    logic [GRP_W-1:0]   dec_inst;
    logic [FETCH_W-1:0] dec_lane_vld;
    logic [FETCH_W-1:0] dec_pred;

    always #5 clk = ~clk;

    fetch_buffer_ctrl #(
        .FETCH_W (FETCH_W),
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .RESET_PC(16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvld     (imem_rvld),
        .imem_rdata    (imem_rdata),
        .bp_taken      (bp_taken),
        .bp_target     (bp_target),
        .has_mispredict(has_mispredict),
        .pc_recovery   (pc_recovery),
        .dec_rdy       (dec_rdy),
        .dec_vld       (dec_vld),
        .dec_pc        (dec_pc),
        .dec_inst      (dec_inst),
        .dec_lane_vld  (dec_lane_vld),
        .dec_pred      (dec_pred)
    );

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [FETCH_W-1:0] lv;
        logic [FETCH_W-1:0] pred;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   nreq     = 0;

    logic            pend_vld  = 1'b0;
    logic [PC_W-1:0] pend_addr = '0;
    logic            tk_en     = 1'b0;
    logic [PC_W-1:0] tk_addr   = '0;
    logic [3:0]      tk_bits   = '0;
    logic [PC_W-1:0] tk_target = '0;

    function automatic logic [GRP_W-1:0] group_of(input logic [PC_W-1:0] a);
        logic [GRP_W-1:0] g;
        g = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            g[i*INST_W +: INST_W] = (a + 16'(i)) ^ 16'hC3C3;
        end
        return g;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic [3:0] lv, input logic [3:0] pred);
        exp_t e;
        e.pc   = pc;
        e.lv   = lv;
        e.pred = pred;
        exp_q.push_back(e);
    endtask

    // One cycle: drive all inputs at negedge (response for last cycle's request), sample at negedge+1.
    task automatic tick(input logic r, input logic mis, input logic rdy, input logic [PC_W-1:0] rec);
        exp_t e;
        @(negedge clk);
        rst            = r;
        has_mispredict = mis;
        dec_rdy        = rdy;
        pc_recovery    = rec;
        imem_rvld      = pend_vld;
        imem_rdata     = pend_vld ? group_of(pend_addr) : '0;
        bp_taken       = (pend_vld && tk_en && (pend_addr == tk_addr)) ? tk_bits : 4'b0000;
        bp_target      = tk_target;
        #1;
        if (!r && dec_vld && rdy && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            check("grp_pc", 64'(dec_pc), 64'(e.pc));
            check("grp_lane_vld", 64'(dec_lane_vld), 64'(e.lv));
            check("grp_pred", 64'(dec_pred), 64'(e.pred));
            check("grp_inst", dec_inst, group_of(e.pc));
            pop_cyc.push_back(cyc);
        end
        pend_vld  = imem_req;
        pend_addr = imem_addr;
        if (imem_req) nreq++;
        cyc++;
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < bound)) begin
            tick(1'b0, 1'b0, 1'b1, 16'h0000);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rst_dec_vld", 64'(dec_vld), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_lane_vld", 64'(dec_lane_vld), 64'd0);
        check("rst_dec_inst", dec_inst, 64'd0);

        // Sequential fetch from RESET_PC
        push(16'h0000, 4'hF, 4'h0);
        push(16'h0004, 4'hF, 4'h0);
        push(16'h0008, 4'hF, 4'h0);
        push(16'h000C, 4'hF, 4'h0);
        push(16'h0010, 4'hF, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", 64'(imem_addr), 64'd0);
        drain("seq_drain", 30);
        check("seq_consec", (pop_cyc.size() >= 4) ? 64'(pop_cyc[3] - pop_cyc[0]) : 64'hDEAD, 64'd3);

        // Prediction: lane 2 taken in group 8, redirect to 0x40
        tk_en = 1'b1; tk_addr = 16'h0008; tk_bits = 4'b0100; tk_target = 16'h0040;
        tick(1'b0, 1'b1, 1'b1, 16'h0000);
        push(16'h0000, 4'hF, 4'h0);
        push(16'h0004, 4'hF, 4'h0);
        push(16'h0008, 4'b0111, 4'b0100);
        push(16'h0040, 4'hF, 4'h0);
        push(16'h0044, 4'hF, 4'h0);
        drain("pred_drain", 30);
        tk_en = 1'b0;

        // Back-pressure: buffer fills to DEPTH and requests stop
        tick(1'b0, 1'b1, 1'b0, 16'h0200);
        nreq = 0;
        repeat (8) tick(1'b0, 1'b0, 1'b0, 16'h0000);
        check("bp_nreq", 64'(nreq), 64'd4);
        check("bp_req_off", 64'(imem_req), 64'd0);
        check("bp_vld", 64'(dec_vld), 64'd1);
        check("bp_head_pc", 64'(dec_pc), 64'h0200);
        push(16'h0200, 4'hF, 4'h0);
        push(16'h0204, 4'hF, 4'h0);
        push(16'h0208, 4'hF, 4'h0);
        push(16'h020C, 4'hF, 4'h0);
        push(16'h0210, 4'hF, 4'h0);
        drain("bp_drain", 30);

        // Recovery with three groups buffered
        tick(1'b0, 1'b1, 1'b0, 16'h0300);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 16'h0000);
        check("rec_pre_pc", 64'(dec_pc), 64'h0300);
        tick(1'b0, 1'b1, 1'b0, 16'h0100);
        push(16'h0100, 4'hF, 4'h0);
        push(16'h0104, 4'hF, 4'h0);
        push(16'h0108, 4'hF, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        check("rec_flush_vld", 64'(dec_vld), 64'd0);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        check("rec_gap_vld", 64'(dec_vld), 64'd0);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        check("rec_lat_vld", 64'(dec_vld), 64'd1);
        drain("rec_drain", 30);

        // PC wrap at 2^PC_W
        tick(1'b0, 1'b1, 1'b1, 16'hFFF8);
        push(16'hFFF8, 4'hF, 4'h0);
        push(16'hFFFC, 4'hF, 4'h0);
        push(16'h0000, 4'hF, 4'h0);
        push(16'h0004, 4'hF, 4'h0);
        drain("wrap_drain", 30);

        // Reset mid-drain leaves no residue
        tick(1'b0, 1'b1, 1'b0, 16'h0500);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        tick(1'b1, 1'b0, 1'b1, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        check("mrst_dec_vld", 64'(dec_vld), 64'd0);
        check("mrst_addr", 64'(imem_addr), 64'd0);
        check("mrst_req", 64'(imem_req), 64'd1);
        push(16'h0000, 4'hF, 4'h0);
        push(16'h0004, 4'hF, 4'h0);
        push(16'h0008, 4'hF, 4'h0);
        drain("mrst_drain", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
